// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter sharing one registered signed comparator (EQ/LT/GT) among NREQ requesters.
// Optional per-requester unsigned compare select is enabled with macro CMP_ARB_UNSIGNED_EN.
module cmp_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 32,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_eq,
   output logic              rsp_lt,
   output logic              rsp_gt,
   output logic              busy
`ifdef CMP_ARB_UNSIGNED_EN
   ,
   input  logic [NREQ-1:0]   req_uns,
   output logic              rsp_uns
`endif
);

   typedef enum logic [1:0] {IDLE, CMP, RESP} stateT;

   stateT          state, nextState;
   logic [IDW-1:0] rrPtr;
   logic [IDW-1:0] grantIdx;
   logic [IDW-1:0] cand;
   logic           grantFound;
   logic           load;
   logic [W-1:0]   aSel, bSel;
   logic [W-1:0]   aR, bR;
   logic [IDW-1:0] idR;
   logic           eqR, ltR, gtR;
   logic           unsR;
   logic           eqNext, ltNext, gtNext;

   // Rotating priority: first valid requester strictly after the last one granted.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
      grantFound = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(rrPtr) + k) % NREQ);
         if (!grantFound && req_valid[cand]) begin
            grantFound = 1'b1;
            grantIdx   = cand;
         end
      end
   end

   assign aSel = req_a[grantIdx*W +: W];
   assign bSel = req_b[grantIdx*W +: W];

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // rst_n gates the accept pulse so nothing is granted while reset is held.
   always_comb begin
      nextState = state;
      req_ready = '0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (grantFound && rst_n) begin
               req_ready[grantIdx] = 1'b1;
               load                = 1'b1;
               nextState           = CMP;
            end
         end
         CMP:     nextState = RESP;
         RESP:    if (rsp_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

`ifdef CMP_ARB_UNSIGNED_EN
   assign ltNext = unsR ? (aR < bR) : ($signed(aR) < $signed(bR));
   assign gtNext = unsR ? (aR > bR) : ($signed(aR) > $signed(bR));
`else
   assign ltNext = $signed(aR) < $signed(bR);
   assign gtNext = $signed(aR) > $signed(bR);
`endif
   assign eqNext = (aR == bR);

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: operand/result registers are plain flops (not a memory), so they reset with the FSM.
      if (!rst_n) begin
         rrPtr <= IDW'(NREQ - 1);
         aR    <= '0;
         bR    <= '0;
         idR   <= '0;
         eqR   <= 1'b0;
         ltR   <= 1'b0;
         gtR   <= 1'b0;
         unsR  <= 1'b0;
      end else begin
         if (load) begin
            aR    <= aSel;
            bR    <= bSel;
            idR   <= grantIdx;
            rrPtr <= grantIdx;
`ifdef CMP_ARB_UNSIGNED_EN
            unsR  <= req_uns[grantIdx];
`else
            unsR  <= 1'b0;
`endif
         end
         if (state == CMP) begin
            eqR <= eqNext;
            ltR <= ltNext;
            gtR <= gtNext;
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign rsp_id    = idR;
   assign rsp_eq    = eqR;
   assign rsp_lt    = ltR;
   assign rsp_gt    = gtR;

`ifdef CMP_ARB_UNSIGNED_EN
   assign rsp_uns = unsR & rsp_valid;
`endif

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Directed bench for cmp_rr_arbiter: reset, single compare, backpressure, mid-op reset,
// round-robin order and boundary operands, each checked with an immediate assertion.
module tb_cmp_rr_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 32;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a, req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_eq, rsp_lt, rsp_gt;
   logic              busy;
`ifdef CMP_ARB_UNSIGNED_EN
   logic [NREQ-1:0]   req_uns;
   logic              rsp_uns;
`endif

   int nAsserts = 0;
   int nFails   = 0;

   always #5 clk = ~clk;

   cmp_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_eq    (rsp_eq),
      .rsp_lt    (rsp_lt),
      .rsp_gt    (rsp_gt),
      .busy      (busy)
`ifdef CMP_ARB_UNSIGNED_EN
      ,
      .req_uns   (req_uns),
      .rsp_uns   (rsp_uns)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp)
      else begin
         nFails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic setOps(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic checkRsp(input string tag, input logic [IDW-1:0] id,
                           input logic eq, input logic lt, input logic gt);
      check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_id"},    32'(rsp_id),    32'(id));
      check({tag, "_eq"},    32'(rsp_eq),    32'(eq));
      check({tag, "_lt"},    32'(rsp_lt),    32'(lt));
      check({tag, "_gt"},    32'(rsp_gt),    32'(gt));
   endtask

   // Single isolated request from requester i, starting in IDLE with nothing else pending.
   task automatic single(input string tag, input int i, input logic eq, input logic lt, input logic gt);
      req_valid = NREQ'(1 << i);
      #1;
      check({tag, "_grant"}, 32'(req_ready), 32'(1 << i));
      cyc();
      req_valid = '0;
      check({tag, "_cmp_valid"}, 32'(rsp_valid), 32'd0);
      cyc();
      checkRsp(tag, IDW'(i), eq, lt, gt);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   logic [IDW-1:0] rrId [5];
   logic [2:0]     rrRes [NREQ];

   initial begin
      rrId[0] = 2'd0; rrId[1] = 2'd1; rrId[2] = 2'd2; rrId[3] = 2'd3; rrId[4] = 2'd0;
      // {eq,lt,gt} for the operands loaded below
      rrRes[0] = 3'b100; rrRes[1] = 3'b010; rrRes[2] = 3'b010; rrRes[3] = 3'b001;

      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
`ifdef CMP_ARB_UNSIGNED_EN
      req_uns   = '0;
`endif
      setOps(0, 32'd5,        32'd5);
      setOps(1, 32'hFFFFFFFF, 32'h00000001);
      setOps(2, 32'h80000000, 32'h7FFFFFFF);
      setOps(3, 32'h7FFFFFFF, 32'h80000000);

      // 1: reset held with everyone requesting
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      cyc(); cyc();
      check("rst_ready_held", 32'(req_ready), 32'd0);
      check("rst_busy_held",  32'(busy),      32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_first_grant", 32'(req_ready), 32'b0001);
      cyc();
      req_valid = '0;
      check("rst_busy_cmp",  32'(busy),      32'd1);
      check("rst_ready_cmp", 32'(req_ready), 32'd0);
      cyc();
      checkRsp("rst_rsp", 2'd0, 1'b1, 1'b0, 1'b0);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      check("rst_back_idle", 32'(busy), 32'd0);

      // 2: single compare from requester 1 (-1 vs 1), then 4: backpressure
      req_valid = 4'b0010;
      #1;
      check("single_grant", 32'(req_ready), 32'b0010);
      cyc();
      req_valid = '1;
      check("single_n1_valid", 32'(rsp_valid), 32'd0);
      check("single_n1_ready", 32'(req_ready), 32'd0);
      cyc();
      checkRsp("single_rsp", 2'd1, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         cyc();
         checkRsp("bp_hold", 2'd1, 1'b0, 1'b1, 1'b0);
         check("bp_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      check("bp_next_grant", 32'(req_ready), 32'b0100);
      check("bp_valid_drop", 32'(rsp_valid), 32'd0);

      // 5: reset asserted while the requester-2 compare is in CMP
      cyc();
      check("midrst_in_cmp", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy",  32'(busy),      32'd0);
      check("midrst_valid", 32'(rsp_valid), 32'd0);
      check("midrst_ready", 32'(req_ready), 32'd0);
      check("midrst_id",    32'(rsp_id),    32'd0);
      cyc(); cyc();
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check("midrst_ptr_grant0", 32'(req_ready), 32'b0001);

      // 3: round-robin with everyone requesting and rsp_ready high
      rsp_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         check("rr_grant", 32'(req_ready), 32'(1 << rrId[g]));
         cyc();
         check("rr_gap1_ready", 32'(req_ready), 32'd0);
         cyc();
         check("rr_gap2_ready", 32'(req_ready), 32'd0);
         checkRsp("rr_rsp", rrId[g], rrRes[rrId[g]][2], rrRes[rrId[g]][1], rrRes[rrId[g]][0]);
         cyc();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      #1;
      check("rr_quiet_ready", 32'(req_ready), 32'd0);
      check("rr_quiet_busy",  32'(busy),      32'd0);

      // 6: boundary operands
      setOps(0, 32'h80000000, 32'h80000000);
      single("bnd_min_eq", 0, 1'b1, 1'b0, 1'b0);
      setOps(3, 32'hFFFFFFFF, 32'h00000000);
      single("bnd_m1_lt0", 3, 1'b0, 1'b1, 1'b0);
      single("bnd_min_lt_max", 2, 1'b0, 1'b1, 1'b0);
`ifdef CMP_ARB_UNSIGNED_EN
      req_uns = 4'b0100;
      req_valid = 4'b0100;
      #1;
      check("uns_grant", 32'(req_ready), 32'b0100);
      cyc();
      req_valid = '0;
      cyc();
      checkRsp("uns_rsp", 2'd2, 1'b0, 1'b0, 1'b1);
      check("uns_echo", 32'(rsp_uns), 32'd1);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      req_uns = '0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
